// File: rtl/uart_tx_capture.sv
// 8N1 UART receiver that captures the SoC's serial output into a byte FIFO with status flags.
// Optional end-of-test byte detection is enabled by defining UART_CAP_EOT_DET_EN.
module uart_tx_capture #(
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  EOT_CHAR   = 8'h04
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        sin,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        frame_err,
  output logic        overflow,
  input  logic        clr_err,
  output logic [15:0] byte_cnt,
  output logic        eot,
  output logic [2:0]  dbg_state_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } state_t;

  // Handshake: a pop is taken in any cycle where rd_en=1 and the FIFO is
  // non-empty; the byte and its one-cycle rd_valid strobe appear next cycle.

  logic          sync1_q, sync2_q, prev_q;
  logic          fall;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_req;
  logic          frame_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;
  logic          frame_err_q, overflow_q;
  logic [15:0]   byte_cnt_q;
  logic          pop_ok, push_ok, ovf_set;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q && !sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        cnt_d = '0;
        if (sync2_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees a slot for a push into a full FIFO; a pop
  // against an empty FIFO is ignored even if a push lands that cycle.
  assign pop_ok  = rd_en && (count_q != '0);
  assign push_ok = push_req && ((count_q != DEPTH) || pop_ok);
  assign ovf_set = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      byte_cnt_q  <= 16'h0000;
    end else begin
      rd_valid_q <= pop_ok;
      if (pop_ok) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + AW'(1);
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW + 1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AW + 1)'(1);
      if (push_req) byte_cnt_q <= byte_cnt_q + 16'd1;
      if (clr_err)        frame_err_q <= 1'b0;
      else if (frame_set) frame_err_q <= 1'b1;
      if (clr_err)        overflow_q <= 1'b0;
      else if (ovf_set)   overflow_q <= 1'b1;
    end
  end

`ifdef UART_CAP_EOT_DET_EN
  logic eot_q;

  always_ff @(posedge clk) begin
    if (!rst_b)                                eot_q <= 1'b0;
    else if (clr_err)                          eot_q <= 1'b0;
    else if (push_req && shift_q == EOT_CHAR)  eot_q <= 1'b1;
  end

  assign eot = eot_q;
`else
  logic unused_eot_char;
  assign unused_eot_char = ^EOT_CHAR;
  assign eot = 1'b0;
`endif

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH);
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign byte_cnt    = byte_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_capture.sv
// Self-checking bench for uart_tx_capture: directed scenarios plus a randomized
// frame stream checked against a queue-based model of the capture stage.
module tb_uart_tx_capture;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_LEN  = 10 * CLK_DIV;
  // Negedge index (from start-bit drive) that falls inside the stop-sample cycle.
  localparam int STOP_CYC   = 2 + CLK_DIV / 2 + 9 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_b, sin, rd_en, clr_err;
  logic [7:0]  rd_data;
  logic        rd_valid, fifo_empty, fifo_full, frame_err, overflow, eot;
  logic [15:0] byte_cnt;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         m_cnt;
  logic       m_ferr, m_ovf, m_eot;

  uart_tx_capture #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .EOT_CHAR(8'h04)) dut (
    .clk(clk), .rst_b(rst_b), .sin(sin), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .frame_err(frame_err), .overflow(overflow), .clr_err(clr_err),
    .byte_cnt(byte_cnt), .eot(eot), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0; sin = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    exp_q.delete();
    m_cnt = 0; m_ferr = 1'b0; m_ovf = 1'b0; m_eot = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one full frame; optionally raises rd_en for one cycle at pop_at and
  // captures what that pop returned.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at,
                            output logic pv, output logic [7:0] pd);
    pv = 1'b0; pd = 8'h00;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      if (i == pop_at + 1) begin pv = rd_valid; pd = rd_data; end
      if (i < CLK_DIV)                     sin = 1'b0;
      else if (i < 9 * CLK_DIV)            sin = b[(i - CLK_DIV) / CLK_DIV];
      else                                 sin = stop;
      rd_en = (i == pop_at);
    end
    @(negedge clk);
    sin = 1'b1; rd_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic pv;
    logic [7:0] pd;
    send_frame(b, stop, -10, pv, pd);
    model_frame(b, stop);
  endtask

  task automatic read_byte(output logic v, output logic [7:0] d);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    v = rd_valid; d = rd_data;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ferr = 1'b0; m_ovf = 1'b0; m_eot = 1'b0;
  endtask

  // ---------------- reference model ----------------
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
      else m_ovf = 1'b1;
`ifdef UART_CAP_EOT_DET_EN
      if (b == 8'h04) m_eot = 1'b1;
`endif
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (fifo_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_checks++; if (fifo_full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    n_checks++; if ({rd_valid, rd_data} !== 9'h000) begin n_errors++; $display("FAIL reset_rd: got %b/%h want 0/00", rd_valid, rd_data); end
    n_checks++; if ({frame_err, overflow, eot} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {frame_err, overflow, eot}); end
    n_checks++; if (byte_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", byte_cnt); end
    n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_single_byte();
    logic v; logic [7:0] d;
    do_reset();
    send(8'h55, 1'b1);
    idle(2);
    n_checks++; if (byte_cnt !== 16'd1) begin n_errors++; $display("FAIL single_cnt: got %0d want 1", byte_cnt); end
    n_checks++; if (fifo_empty !== 1'b0) begin n_errors++; $display("FAIL single_nonempty: got %b want 0", fifo_empty); end
    read_byte(v, d);
    n_checks++; if ({v, d} !== {1'b1, 8'h55}) begin n_errors++; $display("FAIL single_read: got %b/%h want 1/55", v, d); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_errors++; $display("FAIL single_empty_after: got %b want 1", fifo_empty); end
  endtask

  task automatic test_bad_stop();
    logic v; logic [7:0] d;
    do_reset();
    send(8'hA3, 1'b0);
    idle(20);
    n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL badstop_ferr: got %b want 1", frame_err); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_errors++; $display("FAIL badstop_empty: got %b want 1", fifo_empty); end
    n_checks++; if (byte_cnt !== 16'd0) begin n_errors++; $display("FAIL badstop_cnt: got %0d want 0", byte_cnt); end
    send(8'h3C, 1'b1);
    idle(2);
    read_byte(v, d);
    n_checks++; if ({v, d} !== {1'b1, 8'h3C}) begin n_errors++; $display("FAIL badstop_next: got %b/%h want 1/3c", v, d); end
    n_checks++; if (byte_cnt !== 16'd1) begin n_errors++; $display("FAIL badstop_cnt2: got %0d want 1", byte_cnt); end
  endtask

  task automatic test_glitch();
    do_reset();
    @(negedge clk); sin = 1'b0;
    idle(4);
    sin = 1'b1;
    idle(30);
    n_checks++; if (byte_cnt !== 16'd0) begin n_errors++; $display("FAIL glitch_cnt: got %0d want 0", byte_cnt); end
    n_checks++; if ({fifo_empty, frame_err} !== 2'b10) begin n_errors++; $display("FAIL glitch_status: got %b want 10", {fifo_empty, frame_err}); end
    n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL glitch_idle: got %0d want 0", dbg_state); end
  endtask

  task automatic test_overflow();
    logic v; logic [7:0] d;
    do_reset();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    idle(2);
    n_checks++; if ({fifo_full, overflow} !== 2'b11) begin n_errors++; $display("FAIL ovf_flags: got %b want 11", {fifo_full, overflow}); end
    n_checks++; if (byte_cnt !== 16'd5) begin n_errors++; $display("FAIL ovf_cnt: got %0d want 5", byte_cnt); end
    for (int i = 1; i <= 4; i++) begin
      read_byte(v, d);
      n_checks++; if ({v, d} !== {1'b1, 8'(i)}) begin n_errors++; $display("FAIL ovf_read%0d: got %b/%h want 1/%h", i, v, d, 8'(i)); end
    end
    read_byte(v, d);
    n_checks++; if (v !== 1'b0) begin n_errors++; $display("FAIL ovf_empty_pop: got rd_valid=%b want 0", v); end
    pulse_clr();
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    logic v; logic [7:0] d;
    do_reset();
    send(8'h11, 1'b0);
    idle(4);
    send(8'h22, 1'b1);
    // Start bit plus data bits 0..3 of 0x9B, then a one-cycle reset.
    for (int i = 0; i < 5 * CLK_DIV; i++) begin
      @(negedge clk);
      sin = (i < CLK_DIV) ? 1'b0 : ((8'h9B >> ((i - CLK_DIV) / CLK_DIV)) & 8'h01) != 0;
    end
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1; sin = 1'b1;
    exp_q.delete(); m_cnt = 0; m_ferr = 1'b0; m_ovf = 1'b0; m_eot = 1'b0;
    idle(2);
    n_checks++; if ({fifo_empty, fifo_full, frame_err, overflow, eot, rd_valid} !== 6'b100000) begin
      n_errors++; $display("FAIL midrst_flags: got %b want 100000", {fifo_empty, fifo_full, frame_err, overflow, eot, rd_valid}); end
    n_checks++; if ({byte_cnt, rd_data, dbg_state} !== 27'h0) begin
      n_errors++; $display("FAIL midrst_vals: got cnt=%0d data=%h state=%0d want 0/00/0", byte_cnt, rd_data, dbg_state); end
    idle(200);
    send(8'h7E, 1'b1);
    idle(2);
    read_byte(v, d);
    n_checks++; if ({v, d} !== {1'b1, 8'h7E}) begin n_errors++; $display("FAIL midrst_next: got %b/%h want 1/7e", v, d); end
    n_checks++; if (byte_cnt !== 16'd1) begin n_errors++; $display("FAIL midrst_cnt: got %0d want 1", byte_cnt); end
  endtask

  task automatic test_simultaneous();
    logic v, pv; logic [7:0] d, pd, b, first;
    do_reset();
    for (int i = 0; i < FIFO_DEPTH; i++) send(8'($urandom_range(0, 255)), 1'b1);
    first = exp_q[0];
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, STOP_CYC, pv, pd);
    void'(exp_q.pop_front());
    model_frame(b, 1'b1);
    idle(2);
    n_checks++; if ({pv, pd} !== {1'b1, first}) begin n_errors++; $display("FAIL simul_full_pop: got %b/%h want 1/%h", pv, pd, first); end
    n_checks++; if ({fifo_full, overflow} !== 2'b10) begin n_errors++; $display("FAIL simul_full_flags: got %b want 10", {fifo_full, overflow}); end
    while (exp_q.size() > 0) begin
      read_byte(v, d);
      n_checks++; if ({v, d} !== {1'b1, exp_q[0]}) begin n_errors++; $display("FAIL simul_drain: got %b/%h want 1/%h", v, d, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, STOP_CYC, pv, pd);
    model_frame(b, 1'b1);
    idle(2);
    n_checks++; if ({pv, fifo_empty} !== 2'b00) begin n_errors++; $display("FAIL simul_empty: got valid=%b empty=%b want 0/0", pv, fifo_empty); end
    read_byte(v, d);
    n_checks++; if ({v, d} !== {1'b1, b}) begin n_errors++; $display("FAIL simul_empty_read: got %b/%h want 1/%h", v, d, b); end
  endtask

  task automatic test_eot();
    logic v; logic [7:0] d;
    do_reset();
    send(8'h41, 1'b1);
    idle(2);
    n_checks++; if (eot !== 1'b0) begin n_errors++; $display("FAIL eot_early: got %b want 0", eot); end
    send(8'h04, 1'b1);
    idle(2);
    n_checks++; if (eot !== m_eot) begin n_errors++; $display("FAIL eot_set: got %b want %b", eot, m_eot); end
    read_byte(v, d);
    n_checks++; if ({v, d} !== {1'b1, 8'h41}) begin n_errors++; $display("FAIL eot_read1: got %b/%h want 1/41", v, d); end
    read_byte(v, d);
    n_checks++; if ({v, d} !== {1'b1, 8'h04}) begin n_errors++; $display("FAIL eot_read2: got %b/%h want 1/04", v, d); end
    pulse_clr();
    n_checks++; if (eot !== 1'b0) begin n_errors++; $display("FAIL eot_clear: got %b want 0", eot); end
  endtask

  task automatic test_back_to_back();
    logic v; logic [7:0] d, b;
    logic stop;
    do_reset();
    for (int f = 0; f < 24; f++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send(b, stop);
      idle($urandom_range(0, 2));
      for (int r = $urandom_range(0, 2); r > 0; r--) begin
        read_byte(v, d);
        if (exp_q.size() > 0) begin
          n_checks++; if ({v, d} !== {1'b1, exp_q[0]}) begin n_errors++; $display("FAIL b2b_read f%0d: got %b/%h want 1/%h", f, v, d, exp_q[0]); end
          void'(exp_q.pop_front());
        end else begin
          n_checks++; if (v !== 1'b0) begin n_errors++; $display("FAIL b2b_empty_read f%0d: got valid=%b want 0", f, v); end
        end
      end
      if ($urandom_range(0, 7) == 0) pulse_clr();
      n_checks++; if (byte_cnt !== 16'(m_cnt)) begin n_errors++; $display("FAIL b2b_cnt f%0d: got %0d want %0d", f, byte_cnt, m_cnt); end
      n_checks++; if ({frame_err, overflow, eot} !== {m_ferr, m_ovf, m_eot}) begin
        n_errors++; $display("FAIL b2b_flags f%0d: got %b want %b", f, {frame_err, overflow, eot}, {m_ferr, m_ovf, m_eot}); end
      n_checks++; if ({fifo_empty, fifo_full} !== {exp_q.size() == 0, exp_q.size() == FIFO_DEPTH}) begin
        n_errors++; $display("FAIL b2b_occ f%0d: got %b want %b", f, {fifo_empty, fifo_full}, {exp_q.size() == 0, exp_q.size() == FIFO_DEPTH}); end
    end
  endtask

  initial begin
    rst_b = 1'b0; sin = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    test_reset();
    test_single_byte();
    test_bad_stop();
    test_glitch();
    test_overflow();
    test_reset_mid_frame();
    test_simultaneous();
    test_eot();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_capture.md
# uart_tx_capture

- Synthesizable serial-capture stage directly downstream of `aging_SoC_top` pin `o_pad_uart0_sout`.
- Deserializes the CPU's 8N1 UART output into bytes and buffers them in a FIFO for the bench or an on-FPGA debug reader.
- Provides frame-error, overflow and byte-count status, plus optional end-of-test detection.
- Sits in the same domain as `tb.clk`.

## Interface
Parameters:
- `CLK_DIV`, 434: `clk` cycles per UART bit (50 MHz / 115200). Must be ≥ 8 and even.
- `FIFO_DEPTH`, 16: byte FIFO entries. Power of two, ≥ 2.
- `EOT_CHAR`, 8'h04: end-of-test byte. Only used when `UART_CAP_EOT_DET_EN` is defined.

Ports:
- `clk` in 1: single clock.
- `rst_b` in 1: reset is synchronous and active-low.
- `sin` in 1: serial line from `o_pad_uart0_sout`. Idle high.
- `rd_en` in 1: FIFO pop request.
- `rd_data` out 8: popped byte. Reset 8'h00.
- `rd_valid` out 1: one-cycle strobe qualifying `rd_data`. Reset 0.
- `fifo_empty` out 1: reset 1.
- `fifo_full` out 1: reset 0.
- `frame_err` out 1: sticky flag. Reset 0.
- `overflow` out 1: sticky flag. Reset 0.
- `clr_err` in 1: clears `frame_err`, `overflow` and `eot`.
- `byte_cnt` out 16: count of accepted frames. Reset 0.
- `eot` out 1: sticky flag. Reset 0.

## Operation
- **Input sync:** `sin` passes through a 2-FF synchronizer; both flops reset to 1. A falling edge is synchronized-low with previous-cycle high.
- **FSM states:** IDLE, START, DATA, STOP, WAITHI. Reset state is IDLE.
- **IDLE:** on a falling edge, go to START and clear the baud counter.
- **START:** sample at `CLK_DIV/2` cycles.
  - Sample low: go to DATA.
  - Sample high: glitch. Return to IDLE and record nothing.
- **DATA:** sample every `CLK_DIV` cycles, 8 bits, LSB first, into a shift register. After bit 7, go to STOP.
- **STOP:** sample one `CLK_DIV` later.
  - High: push the byte to the FIFO and increment `byte_cnt` (16-bit, wraps 0xFFFF→0). Go to IDLE.
  - Low: set `frame_err`, discard the byte, leave `byte_cnt` unchanged, go to WAITHI.
- **WAITHI:** stay until the synchronized line reads high, then go to IDLE. A held-low break yields exactly one `frame_err` and no bytes.
- **Push when full:** the byte is dropped and `overflow` is set. `byte_cnt` still increments, because it counts frames seen.
- **Pop:** `rd_en` with the FIFO non-empty pops one byte. `rd_en` when empty is ignored, and `rd_valid` stays 0.
- **Push and pop in the same cycle:**
  - FIFO full: the pop frees a slot, the push is accepted and `overflow` is not set.
  - FIFO empty: the push lands and the pop is ignored.
- **`clr_err`:** takes priority over a same-cycle set of any sticky flag.
- **Reset mid-frame:** FSM returns to IDLE, the FIFO empties and all flags clear. The remainder of the frame is ignored; its later bits may look like falling edges, and the bench must not rely on them.

## Timing
- Let T = the cycle the falling edge is detected. This is 2–3 cycles after `sin` falls, due to the synchronizer.
- Sample instants:
  - Start bit: T+`CLK_DIV/2`.
  - Data bit k (k=0..7): T+`CLK_DIV/2`+(k+1)·`CLK_DIV`.
  - Stop bit: T+`CLK_DIV/2`+9·`CLK_DIV`.
- FIFO write, `byte_cnt` update and `fifo_empty` falling: registered, visible in the cycle after the stop sample.
- `rd_en` in cycle N → `rd_data`/`rd_valid` in cycle N+1. Occupancy flags update in N+1.
- Back-to-back frames: a start edge is accepted from the cycle after the stop sample, so no idle gap is required.

## Configuration
- Macro `UART_CAP_EOT_DET_EN`.
- **Defined:** an accepted byte equal to `EOT_CHAR` sets sticky `eot` in the same cycle as the push. The byte is still pushed.
- **Undefined:** `eot` is tied 0, the compare logic is absent and `EOT_CHAR` is unused.

## Test plan
- **Single byte:** `CLK_DIV`=16, send 0x55 with a valid stop → `rd_en` yields `rd_data`=0x55 with `rd_valid`=1; `byte_cnt`=1; `fifo_empty`=1 after the pop.
- **Bad stop bit:** send 0xA3 with stop=0 → `frame_err`=1, `fifo_empty`=1, `byte_cnt`=0. Then send 0x3C → 0x3C is read back and `byte_cnt`=1.
- **Glitch:** drive `sin` low for 4 cycles then high (`CLK_DIV`=16) → no push, `byte_cnt`=0, FSM back in IDLE.
- **Overflow:** `FIFO_DEPTH`=4, send 0x01..0x05 unread → `fifo_full`=1, `overflow`=1, `byte_cnt`=5; reads return 0x01..0x04. `clr_err` then clears `overflow`.
- **Reset mid-frame:** assert `rst_b`=0 for 1 cycle after data bit 3 → all outputs return to reset values. A following 0x7E is captured correctly.
- **End of test:** with `UART_CAP_EOT_DET_EN` defined, send 0x41 then 0x04 → `eot` rises with the 0x04 push and both bytes are readable. With the macro undefined, `eot` stays 0.
